// File: rtl/alu_pkg.sv
// Shared ALU encodings and the multiply sequencer state type.
package alu_pkg;
  localparam logic [4:0] PASS_A = 5'b10000;
  localparam logic [4:0] ADD32  = 5'b10100;
  localparam logic [4:0] LSL32  = 5'b11011;
  localparam logic [4:0] LSR32  = 5'b11100;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mul_state_t;
endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Request/result handshake plus the ALU port bundle driven by the sequencer.
interface alu_mul_sequencer_if #(parameter int WIDTH = 16);
  logic             Start;
  logic [WIDTH-1:0] Multiplicand;
  logic [WIDTH-1:0] Multiplier;
  logic             Busy;
  logic             Done;
  logic [31:0]      Product;
  logic [31:0]      AluA;
  logic [31:0]      AluB;
  logic [4:0]       AluFunSel;
  logic             AluWF;
  logic [31:0]      AluOut;

  modport master (
    output Start, Multiplicand, Multiplier, AluOut,
    input  Busy, Done, Product, AluA, AluB, AluFunSel, AluWF
  );

  modport slave (
    input  Start, Multiplicand, Multiplier, AluOut,
    output Busy, Done, Product, AluA, AluB, AluFunSel, AluWF
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiplier that borrows the shared 32-bit ALU for
// both the accumulate and the multiplicand shift, stopping once no set bits remain.
//   state | meaning
//   IDLE  | ALU ports parked, waiting for Start
//   ADD   | Acc + Mcand through the ALU when the current multiplier bit is set
//   SHIFT | Mcand << 1 through the ALU, retire one multiplier bit
//   DONE  | one-cycle result pulse
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  alu_mul_sequencer_if.slave bus
);

  mul_state_t       state, state_nxt;
  logic [31:0]      acc;
  logic [31:0]      mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      product;
  logic             last_iter;

  // Terminate on the final bit position or as soon as no set bits are left above bit 0.
  assign last_iter   = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
  assign bus.Product = product;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            acc    <= '0;
            mcand  <= {{(32-WIDTH){1'b0}}, bus.Multiplicand};
            mplier <= bus.Multiplier;
            cnt    <= '0;
          end
        end
        ADD: begin
          if (mplier[0]) acc <= bus.AluOut;
        end
        SHIFT: begin
          mcand  <= bus.AluOut;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) product <= acc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.Busy      = 1'b0;
    bus.Done      = 1'b0;
    bus.AluA      = '0;
    bus.AluB      = '0;
    bus.AluFunSel = PASS_A;
    bus.AluWF     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Start) state_nxt = ADD;
      end
      ADD: begin
        bus.Busy = 1'b1;
        bus.AluA = acc;
        bus.AluB = mcand;
        if (mplier[0]) begin
          bus.AluFunSel = ADD32;
          bus.AluWF     = 1'b1;
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        bus.Busy      = 1'b1;
        bus.AluA      = mcand;
        bus.AluFunSel = LSL32;
        state_nxt     = last_iter ? DONE : ADD;
      end
      DONE: begin
        bus.Busy  = 1'b1;
        bus.Done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer with a behavioural ALU beside it; expected
// products, Done cycles and add-cycle patterns come from a scoreboard model.
module tb_alu_mul_sequencer;
  import alu_pkg::*;

  localparam int WIDTH = 16;

  typedef struct {
    logic [31:0] product;
    int          done_cyc;
    logic [63:0] wf_mask;
    logic [15:0] x;
    logic [15:0] y;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset;
  int   cyc;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 Clock = ~Clock;

  alu_mul_sequencer_if #(.WIDTH(WIDTH)) bus();

  alu_mul_sequencer #(.WIDTH(WIDTH)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus.slave)
  );

  always_comb begin
    case (bus.AluFunSel)
      ADD32:   bus.AluOut = bus.AluA + bus.AluB;
      LSL32:   bus.AluOut = bus.AluA << 1;
      LSR32:   bus.AluOut = bus.AluA >> 1;
      default: bus.AluOut = bus.AluA;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t e;
    int   k;
    k = 1;
    for (int i = 0; i < 16; i++) if (y[i]) k = i + 1;
    e.product  = {16'h0, x} * {16'h0, y};
    e.done_cyc = 2 * k + 1;
    e.wf_mask  = '0;
    for (int i = 0; i < k; i++) if (y[i]) e.wf_mask[2*i+1] = 1'b1;
    e.x = x;
    e.y = y;
    return e;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                        input int busy_poke, input bit done_poke, input string tag);
    exp_t        e;
    int          done_at;
    bit          busy_ok;
    logic [63:0] wf;
    logic [4:0]  fs1, fs2;
    logic [31:0] a2, prod;
    done_at = -1;
    busy_ok = 1'b1;
    wf      = '0;
    fs1     = '0;
    fs2     = '0;
    a2      = '0;
    prod    = '0;
    sb.push_back(model(x, y));
    bus.Start        = 1'b1;
    bus.Multiplicand = x;
    bus.Multiplier   = y;
    cyc = 0;
    tick();
    bus.Multiplicand = 16'($urandom);
    bus.Multiplier   = 16'($urandom);
    for (int n = 0; n < 40; n++) begin
      if (n > 0) tick();
      bus.Start = 1'b0;
      if (bus.Busy !== 1'b1) busy_ok = 1'b0;
      if (bus.AluWF === 1'b1) wf[cyc] = 1'b1;
      if (cyc == 1) fs1 = bus.AluFunSel;
      if (cyc == 2) begin
        fs2 = bus.AluFunSel;
        a2  = bus.AluA;
      end
      if (bus.Done === 1'b1) begin
        done_at = cyc;
        prod    = bus.Product;
        break;
      end
      if (cyc == busy_poke) begin
        bus.Start        = 1'b1;
        bus.Multiplicand = 16'd7;
        bus.Multiplier   = 16'd7;
      end
    end
    e = sb.pop_front();
    if (done_poke) begin
      bus.Start        = 1'b1;
      bus.Multiplicand = 16'd7;
      bus.Multiplier   = 16'd7;
    end
    check({tag, "_done_cycle"}, 64'(done_at), 64'(e.done_cyc));
    check({tag, "_product"}, 64'(prod), 64'(e.product));
    check({tag, "_busy_span"}, 64'(busy_ok), 64'(1));
    check({tag, "_wf_cycles"}, wf, e.wf_mask);
    check({tag, "_funsel_c1"}, 64'(fs1), 64'(e.y[0] ? ADD32 : PASS_A));
    check({tag, "_funsel_c2"}, 64'(fs2), 64'(LSL32));
    check({tag, "_shift_a_c2"}, 64'(a2), 64'({16'h0, e.x}));
    tick();
    bus.Start = 1'b0;
    check({tag, "_idle_busy"}, 64'(bus.Busy), 64'(0));
    check({tag, "_idle_done"}, 64'(bus.Done), 64'(0));
    check({tag, "_product_hold"}, 64'(bus.Product), 64'(e.product));
  endtask

  initial begin
    int done_seen;
    Reset            = 1'b1;
    bus.Start        = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    cyc              = 0;
    #12;
    check("rst_busy", 64'(bus.Busy), 64'(0));
    check("rst_done", 64'(bus.Done), 64'(0));
    check("rst_product", 64'(bus.Product), 64'(0));
    check("rst_alu_a", 64'(bus.AluA), 64'(0));
    check("rst_alu_b", 64'(bus.AluB), 64'(0));
    check("rst_funsel", 64'(bus.AluFunSel), 64'(PASS_A));
    check("rst_wf", 64'(bus.AluWF), 64'(0));
    @(negedge Clock);
    Reset = 1'b0;
    tick();
    check("idle_funsel", 64'(bus.AluFunSel), 64'(PASS_A));
    check("idle_busy", 64'(bus.Busy), 64'(0));

    run_op(16'd3, 16'd5, 0, 1'b0, "x3y5");
    run_op(16'h1234, 16'h0000, 0, 1'b0, "y0");
    run_op(16'hFFFF, 16'hFFFF, 4, 1'b1, "ffff_poked");
    run_op(16'h0001, 16'h8000, 0, 1'b0, "x1y8000");
    run_op(16'hFFFF, 16'h0001, 0, 1'b0, "xffffy1");

    // Abort a long multiply from inside cycle 6 with an asynchronous reset.
    bus.Start        = 1'b1;
    bus.Multiplicand = 16'hFFFF;
    bus.Multiplier   = 16'hFFFF;
    cyc = 0;
    tick();
    bus.Start = 1'b0;
    repeat (5) tick();
    #3;
    Reset = 1'b1;
    #1;
    check("abort_busy", 64'(bus.Busy), 64'(0));
    check("abort_product", 64'(bus.Product), 64'(0));
    check("abort_done", 64'(bus.Done), 64'(0));
    check("abort_funsel", 64'(bus.AluFunSel), 64'(PASS_A));
    repeat (2) tick();
    @(negedge Clock);
    Reset = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 36; n++) begin
      tick();
      if (bus.Done === 1'b1 || bus.Busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'(0));
    run_op(16'd2, 16'd3, 0, 1'b0, "after_abort");

    for (int r = 0; r < 4; r++) begin
      logic [15:0] rx, ry;
      rx = 16'($urandom);
      ry = 16'($urandom) >> $urandom_range(0, 15);
      run_op(rx, ry, 0, 1'b0, "random");
    end

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
